// File: rtl/demod_pkg.sv
// Shared constants for the coherent demodulator: modulation mode codes, QPSK symbol
// codes and the accumulator width helper.
package demod_pkg;

    localparam logic [2:0] MOD_ASK     = 3'b000;
    localparam logic [2:0] MOD_CARRIER = 3'b001;
    localparam logic [2:0] MOD_BPSK    = 3'b010;
    localparam logic [2:0] MOD_OOK     = 3'b011;
    localparam logic [2:0] MOD_QPSK    = 3'b100;

    localparam logic [1:0] Q_NCOS = 2'b00;
    localparam logic [1:0] Q_SIN  = 2'b01;
    localparam logic [1:0] Q_NSIN = 2'b10;
    localparam logic [1:0] Q_COS  = 2'b11;

    localparam int SAMPLE_W = 12;
    localparam int PROD_W   = 2 * SAMPLE_W;

    // A symbol sum of sps full-scale products plus one guard bit cannot overflow.
    function automatic int acc_width(input int sps);
        return PROD_W + $clog2(sps) + 1;
    endfunction

endpackage

// File: rtl/demod_correlator.sv
// One correlation branch: registered sample x reference product, then an
// integrate-and-dump accumulator steered by the first/last tags of each sample.
module demod_correlator
    import demod_pkg::*;
#(
    parameter int ACC_W = 31
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic signed [SAMPLE_W-1:0] carrier,
    input  logic                       first,
    input  logic                       last,
    output logic signed [ACC_W-1:0]    dump,
    output logic                       dump_valid
);

    logic signed [PROD_W-1:0] prod;
    logic                     p_valid;
    logic                     p_first;
    logic                     p_last;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;

    // A first-tagged product loads rather than adds, which also discards any partial symbol.
    always_comb begin
        acc_next = p_first ? ACC_W'(prod) : acc + ACC_W'(prod);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod       <= '0;
            p_valid    <= 1'b0;
            p_first    <= 1'b0;
            p_last     <= 1'b0;
            acc        <= '0;
            dump       <= '0;
            dump_valid <= 1'b0;
        end else begin
            dump_valid <= 1'b0;
            if (clr) begin
                p_valid <= 1'b0;
                acc     <= '0;
            end else begin
                p_valid <= in_valid;
                if (in_valid) begin
                    prod    <= PROD_W'(sample) * PROD_W'(carrier);
                    p_first <= first;
                    p_last  <= last;
                end
                if (p_valid) begin
                    acc <= acc_next;
                    if (p_last) begin
                        dump       <= acc_next;
                        dump_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/demodulate.sv
// Coherent integrate-and-dump demodulator for ASK/BPSK/QPSK: symbol counter, I/Q
// correlators, per-mode decision and a one-entry valid/ready output buffer.
module demodulate
    import demod_pkg::*;
#(
    parameter int                 SPS        = 64,
    parameter logic signed [31:0] ASK_THRESH = 32'sd1_000_000,
    parameter int                 ACC_W      = acc_width(SPS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 modulation_sel,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] signal_sin,
    input  logic signed [SAMPLE_W-1:0] signal_cos,
    input  logic                       sym_sync,
    output logic [1:0]                 out_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overrun
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;

    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_next;
    logic                    first;
    logic                    last;
    logic [2:0]              mode_q;
    logic                    mode_chg;
    logic                    smp_go;
    logic signed [ACC_W-1:0] dump_i;
    logic signed [ACC_W-1:0] dump_q;
    logic                    dv_i;
    logic                    dv_q;
    logic signed [63:0]      ai;
    logic signed [63:0]      aq;
    logic signed [63:0]      abs_i;
    logic signed [63:0]      abs_q;
    logic [1:0]              dec_bits;
    logic                    supported;
    logic                    dec_fire;

    // A mode change restarts symbol timing; the sample on that cycle is not used.
    assign mode_chg = (modulation_sel != mode_q);
    assign smp_go   = sample_valid && !mode_chg;

    always_comb begin
        first = sym_sync || (cnt == '0);
        last  = 1'b0;
        if (sym_sync) begin
            cnt_next = CW'(1);
        end else if (cnt == CW'(SPS - 1)) begin
            cnt_next = '0;
            last     = 1'b1;
        end else begin
            cnt_next = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            mode_q <= MOD_ASK;
        end else begin
            mode_q <= modulation_sel;
            if (mode_chg) begin
                cnt <= '0;
            end else if (sample_valid) begin
                cnt <= cnt_next;
            end
        end
    end

    demod_correlator #(.ACC_W(ACC_W)) u_corr_i (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (mode_chg),
        .in_valid   (smp_go),
        .sample     (sample),
        .carrier    (signal_sin),
        .first      (first),
        .last       (last),
        .dump       (dump_i),
        .dump_valid (dv_i)
    );

    demod_correlator #(.ACC_W(ACC_W)) u_corr_q (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (mode_chg),
        .in_valid   (smp_go),
        .sample     (sample),
        .carrier    (signal_cos),
        .first      (first),
        .last       (last),
        .dump       (dump_q),
        .dump_valid (dv_q)
    );

    always_comb begin
        ai        = 64'(dump_i);
        aq        = 64'(dump_q);
        abs_i     = ai[63] ? -ai : ai;
        abs_q     = aq[63] ? -aq : aq;
        dec_bits  = 2'b00;
        supported = 1'b1;
        case (modulation_sel)
            MOD_ASK:  dec_bits = {1'b0, (abs_i > 64'(ASK_THRESH))};
            MOD_BPSK: dec_bits = {1'b0, !ai[63]};
            MOD_QPSK: begin
                if (abs_i >= abs_q) begin
                    dec_bits = ai[63] ? Q_NSIN : Q_SIN;
                end else begin
                    dec_bits = aq[63] ? Q_NCOS : Q_COS;
                end
            end
            default:  supported = 1'b0;
        endcase
    end

    assign dec_fire = dv_i && dv_q && supported && !mode_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_bits  <= 2'b00;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (dec_fire) begin
                if (!out_valid || out_ready) begin
                    out_bits  <= dec_bits;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
